// File: rtl/float_pkg.sv
// Shared definitions for the single-precision float datapath (converters, adder, benches).
package float_pkg;

  localparam int FLOAT_BIAS = 127;
  localparam int EXP_W      = 8;
  localparam int FRAC_W     = 23;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exponent;
    logic [FRAC_W-1:0] fraction;
  } float_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    NORMALIZE = 2'd1,
    ROUND     = 2'd2,
    OUTPUT    = 2'd3
  } state_t;

endpackage

// File: rtl/leading_zero_count32.sv
// Combinational leading-zero counter; an all-zero input reports 32.
module leading_zero_count32 (
  input  logic [31:0] value_i,
  output logic [5:0]  count_o
);

  // Scanning upward lets the highest set bit make the final assignment.
  always_comb begin
    count_o = 6'd32;
    for (int i = 0; i < 32; i++) begin
      if (value_i[i]) begin
        count_o = 6'(31 - i);
      end
    end
  end

endmodule

// File: rtl/int_to_float.sv
// Multi-cycle 32-bit signed/unsigned integer to IEEE-754 single converter,
// round-to-nearest-even, one conversion in flight, valid/ready on both sides.
module int_to_float
  import float_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] int_in,
  input  logic        is_signed,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] float_out,
  output logic        inexact
);

  state_t            state_q, state_d;
  logic              sign_q, sign_d;
  logic [31:0]       mag_q, mag_d;
  logic [30:0]       norm_q, norm_d;
  logic [EXP_W-1:0]  exp_q, exp_d;
  logic              zero_q, zero_d;
  float_t            res_q, res_d;
  logic              inexact_q, inexact_d;

  logic [5:0]        lz;
  logic [31:0]       shifted;
  logic              guardBit, stickyBit, roundUp;
  logic [FRAC_W:0]   mantSum;

  leading_zero_count32 u_lzc (
    .value_i (mag_q),
    .count_o (lz)
  );

  assign shifted   = mag_q << lz;
  assign guardBit  = norm_q[7];
  assign stickyBit = |norm_q[6:0];
  assign roundUp   = guardBit & (stickyBit | norm_q[8]);
  assign mantSum   = {1'b0, norm_q[30:8]} + {{FRAC_W{1'b0}}, roundUp};

  always_comb begin
    state_d   = state_q;
    sign_d    = sign_q;
    mag_d     = mag_q;
    norm_d    = norm_q;
    exp_d     = exp_q;
    zero_d    = zero_q;
    res_d     = res_q;
    inexact_d = inexact_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          // 2^31 still fits unsigned, so the most negative input needs no extra bit.
          sign_d  = is_signed & int_in[31];
          mag_d   = sign_d ? (~int_in + 32'd1) : int_in;
          state_d = NORMALIZE;
        end
      end
      NORMALIZE: begin
        norm_d  = shifted[30:0];
        exp_d   = EXP_W'(FLOAT_BIAS + 31) - {2'b00, lz};
        // After normalisation the top bit is clear only for a zero magnitude.
        zero_d  = ~shifted[31];
        state_d = ROUND;
      end
      ROUND: begin
        if (zero_q) begin
          res_d     = '0;
          inexact_d = 1'b0;
        end else begin
          res_d.sign     = sign_q;
          res_d.exponent = exp_q + {{(EXP_W-1){1'b0}}, mantSum[FRAC_W]};
          res_d.fraction = mantSum[FRAC_W-1:0];
          inexact_d      = guardBit | stickyBit;
        end
        state_d = OUTPUT;
      end
      OUTPUT: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      sign_q    <= 1'b0;
      mag_q     <= '0;
      norm_q    <= '0;
      exp_q     <= '0;
      zero_q    <= 1'b0;
      res_q     <= '0;
      inexact_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sign_q    <= sign_d;
      mag_q     <= mag_d;
      norm_q    <= norm_d;
      exp_q     <= exp_d;
      zero_q    <= zero_d;
      res_q     <= res_d;
      inexact_q <= inexact_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == OUTPUT);
  assign float_out = res_q;
  assign inexact   = inexact_q;

endmodule

// File: tb/tb_int_to_float.sv
// Directed scoreboard bench for int_to_float: rounding cases, latency,
// back-pressure and mid-conversion reset.
module tb_int_to_float;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] int_in;
  logic        is_signed;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] float_out;
  logic        inexact;

  int          checks = 0;
  int          errors = 0;
  logic [32:0] sb[$];

  int_to_float dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .int_in    (int_in),
    .is_signed (is_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .float_out (float_out),
    .inexact   (inexact)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hands one operand over and records what the converter must produce for it.
  task automatic applyStimulus(input logic [31:0] val, input logic sgn,
                               input logic [31:0] expF, input logic expX);
    int waitCycles;
    waitCycles = 0;
    while (in_ready !== 1'b1 && waitCycles < 20) begin
      tick();
      waitCycles++;
    end
    check("in_ready_wait", {31'd0, in_ready}, 32'd1);
    int_in    = val;
    is_signed = sgn;
    in_valid  = 1'b1;
    sb.push_back({expF, expX});
    tick();
    in_valid = 1'b0;
    check("in_ready_busy", {31'd0, in_ready}, 32'd0);
  endtask

  // Waits (bounded) for the result, checks latency and value, completes the handshake.
  task automatic checkOutput(input string tag);
    int          cycles;
    logic [32:0] e;
    cycles = 0;
    while (out_valid !== 1'b1 && cycles < 20) begin
      tick();
      cycles++;
    end
    check({tag, "_latency"}, cycles, 32'd2);
    if (out_valid === 1'b1 && sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_float"}, float_out, e[32:1]);
      check({tag, "_inexact"}, {31'd0, inexact}, {31'd0, e[0]});
    end else begin
      check({tag, "_timeout"}, {31'd0, out_valid}, 32'd1);
      if (sb.size() > 0) void'(sb.pop_front());
    end
    if (out_ready === 1'b1) begin
      tick();
      check({tag, "_hs_valid"}, {31'd0, out_valid}, 32'd0);
      check({tag, "_hs_ready"}, {31'd0, in_ready}, 32'd1);
    end
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    int_in    = '0;
    is_signed = 1'b0;
    out_ready = 1'b1;
    repeat (2) tick();
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_float", float_out, 32'h0);
    check("rst_inexact", {31'd0, inexact}, 32'd0);
    reset = 1'b0;

    applyStimulus(32'd1, 1'b0, 32'h3F800000, 1'b0);         checkOutput("u1");
    applyStimulus(32'd2, 1'b0, 32'h40000000, 1'b0);         checkOutput("u2");
    applyStimulus(32'hFFFFFFFF, 1'b1, 32'hBF800000, 1'b0);  checkOutput("s_neg1");
    applyStimulus(32'h80000000, 1'b1, 32'hCF000000, 1'b0);  checkOutput("s_min");
    applyStimulus(32'd0, 1'b1, 32'h00000000, 1'b0);         checkOutput("zero");
    applyStimulus(32'd16777217, 1'b0, 32'h4B800000, 1'b1);  checkOutput("tie_even");
    applyStimulus(32'd16777219, 1'b0, 32'h4B800002, 1'b1);  checkOutput("tie_up");
    applyStimulus(32'h7FFFFFFF, 1'b1, 32'h4F000000, 1'b1);  checkOutput("s_max_carry");
    applyStimulus(32'hFFFFFFFF, 1'b0, 32'h4F800000, 1'b1);  checkOutput("u_max");
    applyStimulus(32'd1000, 1'b0, 32'h447A0000, 1'b0);      checkOutput("u1000");
    applyStimulus(32'hFFFFFC18, 1'b1, 32'hC47A0000, 1'b0);  checkOutput("s_neg1000");

    // Back-pressure: result must hold while a stray in_valid is ignored.
    out_ready = 1'b0;
    applyStimulus(32'd3, 1'b0, 32'h40400000, 1'b0);
    checkOutput("bp");
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        int_in    = 32'hDEADBEEF;
        is_signed = 1'b0;
        in_valid  = 1'b1;
      end
      tick();
      in_valid = 1'b0;
      check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      check("bp_hold_float", float_out, 32'h40400000);
      check("bp_hold_inexact", {31'd0, inexact}, 32'd0);
      check("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    tick();
    check("bp_release_valid", {31'd0, out_valid}, 32'd0);
    check("bp_release_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("bp_no_stray", {31'd0, out_valid}, 32'd0);
    end

    // Reset while in NORMALIZE.
    int_in    = 32'd5;
    is_signed = 1'b0;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    reset    = 1'b1;
    tick();
    reset = 1'b0;
    check("rstn_in_ready", {31'd0, in_ready}, 32'd1);
    check("rstn_out_valid", {31'd0, out_valid}, 32'd0);
    check("rstn_float", float_out, 32'h0);
    check("rstn_inexact", {31'd0, inexact}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rstn_no_result", {31'd0, out_valid}, 32'd0);
    end

    // Reset while in ROUND.
    int_in   = 32'd7;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstr_in_ready", {31'd0, in_ready}, 32'd1);
    check("rstr_out_valid", {31'd0, out_valid}, 32'd0);
    check("rstr_float", float_out, 32'h0);
    check("rstr_inexact", {31'd0, inexact}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rstr_no_result", {31'd0, out_valid}, 32'd0);
    end

    applyStimulus(32'd2, 1'b0, 32'h40000000, 1'b0);
    checkOutput("post_reset");
    check("sb_empty", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
